// File: rtl/raz_request_sequencer.sv
// raz_request_sequencer
// Arbitrates RAZ (analogue channel reset) requests from three sources:
// software command, external trigger level and auto-RAZ from acquisition.
// Each granted request produces one trigger pulse to the RAZ generator with
// that source's mode. The resource then stays busy for the RAZ window plus a
// programmable hold-off. Requests arriving while busy are held one-deep per
// source. A second request on an already pending source is counted as a drop.
//
// Ports
//   i_clk               system clock (40 MHz)
//   i_reset_n           asynchronous active-low reset
//   i_enable            low: ignore new requests, clear pending ones
//   i_soft_raz_req      software request, 1-cycle pulse
//   i_ext_trig_req      external trigger level, rising edge = request
//   i_auto_raz_req      auto request, 1-cycle pulse
//   i_soft/ext/auto_raz_mode  RAZ mode used when that source is granted
//   i_holdoff_time      dead-time cycles after the RAZ window (0 = none)
//   i_drop_count_clear  synchronous clear of o_drop_count
//   o_raz_trigger       1-cycle trigger pulse to the RAZ generator
//   o_raz_mode          mode to the RAZ generator, held from grant onwards
//   o_busy              high whenever the sequencer is not idle
//   o_granted           01 soft, 10 ext, 11 auto, 00 idle
//   o_drop_count        saturating count of dropped requests
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a pending request
// S_GRANT  | one cycle, trigger pulse out, RAZ window counter loaded
// S_ACTIVE | RAZ window running (7/14/24/44 cycles by mode)
// S_HOLDOFF| dead time after the window (latched hold-off value)

module raz_request_sequencer #(
  parameter int DROP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_soft_raz_req,
  input  logic              i_ext_trig_req,
  input  logic              i_auto_raz_req,
  input  logic [1:0]        i_soft_raz_mode,
  input  logic [1:0]        i_ext_raz_mode,
  input  logic [1:0]        i_auto_raz_mode,
  input  logic [7:0]        i_holdoff_time,
  input  logic              i_drop_count_clear,
  output logic              o_raz_trigger,
  output logic [1:0]        o_raz_mode,
  output logic              o_busy,
  output logic [1:0]        o_granted,
  output logic [DROP_W-1:0] o_drop_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  logic [1:0]        r_state;
  logic [7:0]        r_cnt;
  logic [7:0]        r_holdoff;
  logic [1:0]        r_raz_mode;
  logic [1:0]        r_granted;
  logic              r_trig;
  logic              r_ext1;
  logic              r_ext2;
  logic [2:0]        r_pend;      // [2] soft, [1] ext, [0] auto
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_ext_rise;
  logic [2:0]        w_req;
  logic              w_grant_go;
  logic [2:0]        w_clr;
  logic [1:0]        w_win_code;
  logic [1:0]        w_win_mode;
  logic [2:0]        w_drop;
  logic [1:0]        w_drop_n;
  logic [DROP_W:0]   w_drop_sum;
  logic [7:0]        w_win_len;

  // External trigger edge detect
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ext1 <= 1'b0;
      r_ext2 <= 1'b0;
    end else begin
      r_ext1 <= i_ext_trig_req;
      r_ext2 <= r_ext1;
    end
  end

  assign w_ext_rise = r_ext1 & ~r_ext2;
  assign w_req      = {i_soft_raz_req, w_ext_rise, i_auto_raz_req} & {3{i_enable}};
  assign w_grant_go = (r_state == S_IDLE) && i_enable && (|r_pend);

  // Fixed priority soft > ext > auto
  always_comb begin
    w_clr      = 3'b000;
    w_win_code = 2'b00;
    w_win_mode = 2'b00;
    if (w_grant_go) begin
      if (r_pend[2]) begin
        w_clr      = 3'b100;
        w_win_code = 2'b01;
        w_win_mode = i_soft_raz_mode;
      end else if (r_pend[1]) begin
        w_clr      = 3'b010;
        w_win_code = 2'b10;
        w_win_mode = i_ext_raz_mode;
      end else begin
        w_clr      = 3'b001;
        w_win_code = 2'b11;
        w_win_mode = i_auto_raz_mode;
      end
    end
  end

  // A request on a bit that is being granted this edge re-arms it, no drop
  assign w_drop   = w_req & r_pend & ~w_clr;
  assign w_drop_n = 2'(w_drop[0]) + 2'(w_drop[1]) + 2'(w_drop[2]);
  assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W+1)'(w_drop_n);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend <= 3'b000;
    end else if (!i_enable) begin
      r_pend <= 3'b000;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_req;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_drop_cnt <= '0;
    end else if (i_drop_count_clear) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum[DROP_W]) begin
      r_drop_cnt <= '1;
    end else begin
      r_drop_cnt <= w_drop_sum[DROP_W-1:0];
    end
  end

  // RAZ window: generator pulse length {3,10,20,40} plus 4 cycles of margin
  always_comb begin
    case (r_raz_mode)
      2'b00:   w_win_len = 8'd7;
      2'b01:   w_win_len = 8'd14;
      2'b10:   w_win_len = 8'd24;
      default: w_win_len = 8'd44;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_holdoff  <= 8'd0;
      r_raz_mode <= 2'b00;
      r_granted  <= 2'b00;
      r_trig     <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_go) begin
            r_state    <= S_GRANT;
            r_trig     <= 1'b1;
            r_raz_mode <= w_win_mode;
            r_granted  <= w_win_code;
            // latched so that input changes mid-sequence have no effect
            r_holdoff  <= i_holdoff_time;
          end
        end
        S_GRANT: begin
          r_state <= S_ACTIVE;
          r_cnt   <= w_win_len - 8'd1;
        end
        S_ACTIVE: begin
          if (r_cnt == 8'd0) begin
            if (r_holdoff != 8'd0) begin
              r_state <= S_HOLDOFF;
              r_cnt   <= r_holdoff - 8'd1;
            end else begin
              r_state   <= S_IDLE;
              r_granted <= 2'b00;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          if (r_cnt == 8'd0) begin
            r_state   <= S_IDLE;
            r_granted <= 2'b00;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
      endcase
    end
  end

  assign o_raz_trigger = r_trig;
  assign o_raz_mode    = r_raz_mode;
  assign o_busy        = (r_state != S_IDLE);
  assign o_granted     = r_granted;
  assign o_drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_raz_request_sequencer.sv
`timescale 1ns/1ps
module tb_raz_request_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        soft_req, ext_req, auto_req;
  logic [1:0]  soft_mode, ext_mode, auto_mode;
  logic [7:0]  holdoff;
  logic        drop_clr;
  logic        raz_trig;
  logic [1:0]  raz_mode;
  logic        busy;
  logic [1:0]  granted;
  logic [15:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #12.5 clk = ~clk;

  raz_request_sequencer #(.DROP_W(16)) dut (
    .i_clk              (clk),
    .i_reset_n          (reset_n),
    .i_enable           (enable),
    .i_soft_raz_req     (soft_req),
    .i_ext_trig_req     (ext_req),
    .i_auto_raz_req     (auto_req),
    .i_soft_raz_mode    (soft_mode),
    .i_ext_raz_mode     (ext_mode),
    .i_auto_raz_mode    (auto_mode),
    .i_holdoff_time     (holdoff),
    .i_drop_count_clear (drop_clr),
    .o_raz_trigger      (raz_trig),
    .o_raz_mode         (raz_mode),
    .o_busy             (busy),
    .o_granted          (granted),
    .o_drop_count       (drop_cnt)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic busy_high_len(output int w);
    w = 0;
    while (busy && w < 1000) begin
      w++;
      tick();
    end
  endtask

  task automatic busy_low_len(output int g);
    g = 0;
    while (!busy && g < 1000) begin
      g++;
      tick();
    end
  endtask

  task automatic count_trig(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (raz_trig) c++;
      tick();
    end
  endtask

  // Soft grant (mode 11, hold-off 255 -> 300 busy cycles); then n edges of
  // held requests inside the busy window, giving 2*(n-1) drops with auto,
  // n-1 without. Pending bits are flushed by a disable cycle.
  task automatic drop_chunk(input int n, input bit with_auto);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    tick();
    soft_req = 1'b1;
    auto_req = with_auto;
    tick(n);
    soft_req = 1'b0;
    auto_req = 1'b0;
    enable   = 1'b0;
    tick();
    enable   = 1'b1;
    tick(303 - n);
  endtask

  int w, g, c;
  int exp_w[3];
  int exp_gr[3];
  int exp_md[3];

  initial begin
    exp_w  = '{13, 20, 30};
    exp_gr = '{1, 2, 3};
    exp_md = '{0, 1, 2};

    reset_n   = 1'b0;
    enable    = 1'b1;
    soft_req  = 1'b0;
    ext_req   = 1'b0;
    auto_req  = 1'b0;
    soft_mode = 2'b00;
    ext_mode  = 2'b01;
    auto_mode = 2'b10;
    holdoff   = 8'd0;
    drop_clr  = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("rst_trig", raz_trig, 0);
    chk("rst_mode", raz_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_granted", granted, 0);
    chk("rst_drop", drop_cnt, 0);

    // Single soft request, mode 00, no hold-off
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("t1_busy_k", busy, 0);
    chk("t1_trig_k", raz_trig, 0);
    tick();
    chk("t1_trig_k1", raz_trig, 1);
    chk("t1_granted", granted, 1);
    chk("t1_mode", raz_mode, 0);
    tick();
    chk("t1_trig_k2", raz_trig, 0);
    busy_high_len(w);
    chk("t1_busy_width", w + 1, 8);
    chk("t1_granted_idle", granted, 0);
    chk("t1_drop", drop_cnt, 0);
    tick(5);

    // Three sources at once, hold-off 5
    holdoff  = 8'd5;
    soft_req = 1'b1;
    auto_req = 1'b1;
    ext_req  = 1'b1;
    tick();
    soft_req = 1'b0;
    auto_req = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("t2_trig_%0d", s), raz_trig, 1);
      chk($sformatf("t2_granted_%0d", s), granted, exp_gr[s]);
      chk($sformatf("t2_mode_%0d", s), raz_mode, exp_md[s]);
      busy_high_len(w);
      chk($sformatf("t2_width_%0d", s), w, exp_w[s]);
      if (s < 2) begin
        busy_low_len(g);
        chk($sformatf("t2_gap_%0d", s), g, 1);
      end
    end
    chk("t2_granted_idle", granted, 0);
    chk("t2_mode_kept", raz_mode, 2);
    ext_req = 1'b0;
    count_trig(60, c);
    chk("t2_no_extra", c, 0);
    chk("t2_drop", drop_cnt, 0);

    // Auto mode 11, three extra pulses during ACTIVE
    holdoff   = 8'd0;
    auto_mode = 2'b11;
    auto_req  = 1'b1;
    tick();
    auto_req = 1'b0;
    tick();
    chk("t3_granted", granted, 3);
    tick();
    for (int i = 0; i < 3; i++) begin
      auto_req = 1'b1;
      tick();
      auto_req = 1'b0;
      tick();
    end
    chk("t3_drop", drop_cnt, 2);
    count_trig(200, c);
    chk("t3_one_more", c, 1);
    chk("t3_idle", busy, 0);

    // Disable with pending ext request and toggling ext input
    soft_mode = 2'b00;
    soft_req  = 1'b1;
    tick();
    soft_req = 1'b0;
    tick();
    ext_req = 1'b1;
    tick(2);
    enable = 1'b0;
    tick();
    chk("t4_busy_runs", busy, 1);
    c = 0;
    for (int i = 0; i < 40; i++) begin
      ext_req = (i < 8) ? ~ext_req : 1'b0;
      if (raz_trig) c++;
      tick();
    end
    enable = 1'b1;
    tick(2);
    count_trig(30, w);
    chk("t4_no_grant", c + w, 0);
    chk("t4_idle", busy, 0);
    chk("t4_drop", drop_cnt, 2);

    // Drop counter saturation
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("t5_cleared", drop_cnt, 0);
    soft_mode = 2'b11;
    holdoff   = 8'd255;
    drop_chunk(290, 1'b1);
    chk("t5_chunk1", drop_cnt, 578);
    for (int i = 1; i < 113; i++) drop_chunk(290, 1'b1);
    drop_chunk(111, 1'b1);
    chk("t5_fffe", drop_cnt, 16'hFFFE);
    drop_chunk(4, 1'b0);
    chk("t5_saturate", drop_cnt, 16'hFFFF);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    tick();
    soft_req = 1'b1;
    tick();
    drop_clr = 1'b1;
    tick();
    chk("t5_clr_priority", drop_cnt, 0);
    soft_req = 1'b0;
    drop_clr = 1'b0;
    tick();
    chk("t5_clr_hold", drop_cnt, 0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick(305);

    // Reset in the middle of ACTIVE
    holdoff  = 8'd0;
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    tick(2);
    soft_req = 1'b1;
    tick(2);
    soft_req = 1'b0;
    tick(3);
    chk("t6_drop_pre", drop_cnt, 1);
    chk("t6_mode_pre", raz_mode, 3);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_trig", raz_trig, 0);
    chk("t6_rst_mode", raz_mode, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_granted", granted, 0);
    chk("t6_rst_drop", drop_cnt, 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("t6_no_pending", busy, 0);
    soft_mode = 2'b01;
    soft_req  = 1'b1;
    tick();
    soft_req = 1'b0;
    tick();
    chk("t6_trig", raz_trig, 1);
    chk("t6_granted", granted, 1);
    chk("t6_mode", raz_mode, 1);
    busy_high_len(w);
    chk("t6_width", w, 15);
    count_trig(40, c);
    chk("t6_no_extra", c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/raz_request_sequencer.md
# raz_request_sequencer

Arbitrates RAZ (analogue channel reset) requests from three sources (software command, external trigger, auto-RAZ from the acquisition FSM) and sequences the external RAZ generator. It issues one trigger pulse per granted request together with the RAZ mode of that source. It then holds the resource busy for the full RAZ pulse plus a programmable hold-off. Requests that arrive while busy are kept one-deep per source, and overflows are counted. Sits between the command decoder / acquisition control and the RAZ generator on the DIF FPGA.

## Interface
- DROP_W, 16, width of saturating drop counter

Ports:
- Clk  in  1  system clock (40 MHz, 25 ns)
- reset_n  in  1  asynchronous, active-low reset
- Enable  in  1  sequencer enable; low = ignore new requests, clear pending
- SoftRazReq  in  1  software request, 1-cycle pulse, synchronous
- ExtTrigReq  in  1  external trigger level, rising edge = request
- AutoRazReq  in  1  auto request, 1-cycle pulse, synchronous
- SoftRazMode  in  2  RAZ mode for soft grants
- ExtRazMode  in  2  RAZ mode for ext grants
- AutoRazMode  in  2  RAZ mode for auto grants
- HoldoffTime  in  8  dead-time cycles after RAZ window; 0 = none
- DropCountClear  in  1  synchronous clear of DropCount
- RazTrigger  out  1  1-cycle pulse to RAZ generator trigger input
- RazMode  out  2  mode to RAZ generator, stable GRANT..end of HOLDOFF
- Busy  out  1  high whenever state != IDLE
- Granted  out  2  01 soft, 10 ext, 11 auto, 00 idle
- DropCount  out  DROP_W  saturating count of dropped requests

## Operation
- Ext edge detect: Ext1<=ExtTrigReq, Ext2<=Ext1; ExtRise = Ext1 & ~Ext2.
- Pending bits P[soft,ext,auto]: a request (SoftRazReq/ExtRise/AutoRazReq) with Enable=1 sets its bit. A request while its bit is already 1 and not cleared the same cycle is a drop.
- Grant clear and new request on the same source, same edge: bit stays 1, no drop.
- Enable=0: all P cleared; requests are ignored and not counted; an in-progress sequence runs to IDLE.
- FSM states: IDLE, GRANT, ACTIVE, HOLDOFF.
- IDLE: if any P, go to GRANT at the next edge. Priority is soft > ext > auto. Clear the winner's P, load RazMode and Granted from the winner.
- GRANT (1 cycle): RazTrigger=1. Load the window counter with L = {3,10,20,40}[RazMode] + 4 = 7/14/24/44. Go to ACTIVE.
- ACTIVE: count L cycles. Then go to HOLDOFF if HoldoffTime != 0, else IDLE.
- HOLDOFF: count HoldoffTime cycles (value sampled on entry), then go to IDLE.
- Return to IDLE: Granted = 00. RazMode keeps its last value.
- DropCount: add the number of drops in the cycle (0..3). Saturate at 2^DROP_W-1. DropCountClear has priority over increment.

## Timing
- Reset values: RazTrigger 0, RazMode 00, Busy 0, Granted 00, DropCount 0, P 000, state IDLE. Reset asserted mid-sequence aborts immediately.
- Soft/auto request sampled at edge k: P set after k. GRANT after k+1, where RazTrigger, Busy and Granted go high. RazTrigger falls after k+2.
- Ext: the rising edge of ExtTrigReq is sampled into Ext1 at edge j. ExtRise is high in cycle j..j+1. The P bit is set at edge j+1, and GRANT follows at edge j+2.
- Busy duration per grant: 1 + L + HoldoffTime cycles.
- Back-to-back: the next grant is entered on the first edge after the IDLE state is reached. Busy therefore drops for exactly 1 cycle between sequences.
- RazMode/HoldoffTime input changes during a sequence do not affect it.

## Test plan
- Soft pulse, SoftRazMode=00, HoldoffTime=0 -> RazTrigger high 1 cycle at 2 edges after the request; Busy high 8 cycles; Granted=01; DropCount=0.
- Soft, ext and auto requests in the same cycle, modes 00/01/10, HoldoffTime=5 -> grants in order 01, 10, 11. Busy widths 13, 20, 30 cycles with 1-cycle gaps. RazMode is 00, 01, 10 respectively.
- Auto mode 11 busy; three AutoRazReq pulses during ACTIVE -> first is pending, DropCount=2; exactly one further grant follows.
- Enable=0 with a pending ext request and ExtTrigReq toggling -> P cleared, no new grant, DropCount unchanged; the current sequence completes.
- DropCount preloaded to 0xFFFE via drops, then 3 drops -> stays 0xFFFF; DropCountClear together with a drop -> 0.
- reset_n low in the middle of ACTIVE -> all outputs at reset values immediately. After release, a new soft request is granted normally.
